me_block_loader: RTL and testbench
==================================

ME_BLOCK_LOADER -- requirements
Module: me_block_loader

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1 / in_data  in  8 / in_ready  out  1  pixel stream, beat = in_valid & in_ready.
REQ-004 SHALL have ports: r_we  out  1 / r_addr  out  8 / r_wdata  out  8  reference-block memory write port (256 x 8).
REQ-005 SHALL have ports: s_we  out  1 / s_addr  out  10 / s_wdata  out  8  search-window memory write port (1024 x 8, 32 x 32 raster).
REQ-006 SHALL have ports: start  out  1 / completed  in  1  motion-search engine control; engine counts while start=1 and halts on completed.
REQ-007 SHALL have ports: bestDistance  in  8 / motionX  in  4 / motionY  in  4  engine results.
REQ-008 SHALL have ports: res_valid  out  1 / res_ready  in  1 / res_dist  out  8 / res_mx  out  4 / res_my  out  4  result handshake.
REQ-009 SHALL have ports: busy  out  1  high in every state except LOAD_R with zero beats taken.
REQ-010 SHALL have parameters: R_WORDS, default 256, reference pixel count; S_WORDS, default 1024, search pixel count.

Function
REQ-011 SHALL implement states LOAD_R, LOAD_S, RUN, CAPTURE, RESULT.
REQ-012 LOAD_R: in_ready=1; each beat writes in_data to r_addr=beat index (0..255) same cycle, r_we=1 combinationally on beat; after beat 255 -> LOAD_S.
REQ-013 LOAD_S: in_ready=1; each beat writes s_addr=beat index (0..1023), s_we=1 on beat; after beat 1023 -> RUN.
REQ-014 Beat index SHALL be one shared 10-bit counter, cleared on each state entry; no beat lost or duplicated under any in_valid gap pattern.
REQ-015 r_we and s_we SHALL never be high together; neither high outside its load state.
REQ-016 RUN: start=1 registered, asserted on the cycle after the final S beat; in_ready=0; on completed=1 -> CAPTURE.
REQ-017 CAPTURE: start held 1 (engine frozen); on this edge register bestDistance/motionX/motionY into res_* -> RESULT (one-cycle settle after completed).
REQ-018 RESULT: res_valid=1, res_* stable, start held 1; on res_valid & res_ready -> LOAD_R, start=0 next cycle (engine counter clears).
REQ-019 start SHALL drop for at least one cycle between consecutive searches.
REQ-020 Beats offered in RUN/CAPTURE/RESULT SHALL not be accepted (in_ready=0); stream stalls.
REQ-021 completed observed outside RUN SHALL be ignored.
REQ-022 Input data SHALL be written unmodified; no arithmetic beyond counter increment; counter wraps only via state-entry clear.

Reset
REQ-023 reset=1 SHALL, at next edge, force state LOAD_R, counter 0, start=0, res_valid=0, res_* =0, r_we=s_we=0, in_ready=1 the following cycle.
REQ-024 reset mid-load or mid-run SHALL abort the operation; partial memory contents are not erased; reset dominates simultaneous beats and completed.

Structure
REQ-025 R_WORDS, S_WORDS, search width 32 and state encodings SHALL live in the shared motion-estimation package/header.
REQ-026 The beat counter with clear/increment/terminal-count SHALL be the one sub-module, me_load_counter.

Verification
REQ-027 Continuous stream of 1280 beats, R[i]=i, S[j]=j[7:0] -> r_addr 0..255, s_addr 0..1023 written in order, start rises cycle after beat 1279.
REQ-028 in_valid toggled randomly at 50% -> exactly 256 r_we and 1024 s_we pulses, addresses gapless.
REQ-029 Engine model asserts completed 4111 cycles after start with bestDistance=0x12, motionX=3, motionY=0xD -> res_valid with res_dist=0x12, res_mx=3, res_my=0xD, start still 1.
REQ-030 res_ready held 0 for 20 cycles -> res_* stable, start stays 1; res_ready=1 -> start=0 next cycle, in_ready=1.
REQ-031 reset at beat 600 of LOAD_S -> start=0, in_ready=1, next beat writes r_addr=0.
REQ-032 completed pulsed during LOAD_R, in_valid high during RUN -> no state change, no write, in_ready=0 in RUN.

Source files
------------

// File: rtl/me_block_loader_pkg.sv
// Shared motion-estimation constants and loader state encoding.
package me_block_loader_pkg;

  localparam int R_WORDS_DEF = 256;
  localparam int S_WORDS_DEF = 1024;
  localparam int SEARCH_W    = 32;
  localparam int CNT_W       = 10;

  typedef enum logic [2:0] {
    ST_LOAD_R  = 3'd0,
    ST_LOAD_S  = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

endpackage

// File: rtl/me_block_loader_if.sv
// Pixel stream and result handshake bundle; slave is the loader's view.
interface me_block_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_dist;
  logic [3:0] res_mx;
  logic [3:0] res_my;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_dist, res_mx, res_my
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_dist, res_mx, res_my
  );

endinterface

// File: rtl/me_load_counter.sv
// Shared beat counter: clear has priority over increment, tc flags the last index.
module me_load_counter
  import me_block_loader_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = (count_q == last);

endmodule

// File: rtl/me_block_loader.sv
// Streams reference and search pixels into their memories, runs the engine, returns its result.
module me_block_loader
  import me_block_loader_pkg::*;
#(
  parameter int R_WORDS = R_WORDS_DEF,
  parameter int S_WORDS = S_WORDS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  me_block_loader_if.slave  px,
  output logic              r_we,
  output logic [7:0]        r_addr,
  output logic [7:0]        r_wdata,
  output logic              s_we,
  output logic [9:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              start,
  input  logic              completed,
  input  logic [7:0]        bestDistance,
  input  logic [3:0]        motionX,
  input  logic [3:0]        motionY,
  output logic              busy
);

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_dist_q, res_dist_d;
  logic [3:0]       res_mx_q, res_mx_d;
  logic [3:0]       res_my_q, res_my_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;
  logic             tc;
  logic             beat;
  logic             loading;

  // Reset masks in_ready so a beat offered alongside reset is never written.
  assign loading     = (state_q == ST_LOAD_R) || (state_q == ST_LOAD_S);
  assign px.in_ready = loading && !reset;
  assign beat        = px.in_valid && px.in_ready;
  assign last        = (state_q == ST_LOAD_R) ? CNT_W'(R_WORDS - 1) : CNT_W'(S_WORDS - 1);

  me_load_counter u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (state_d != state_q),
    .inc   (beat),
    .last  (last),
    .count (count),
    .tc    (tc)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    res_valid_d = res_valid_q;
    res_dist_d  = res_dist_q;
    res_mx_d    = res_mx_q;
    res_my_d    = res_my_q;
    case (state_q)
      ST_LOAD_R: if (beat && tc) state_d = ST_LOAD_S;
      ST_LOAD_S: begin
        if (beat && tc) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: if (completed) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        res_dist_d  = bestDistance;
        res_mx_d    = motionX;
        res_my_d    = motionY;
        res_valid_d = 1'b1;
        state_d     = ST_RESULT;
      end
      ST_RESULT: begin
        if (px.res_ready) begin
          res_valid_d = 1'b0;
          start_d     = 1'b0;
          state_d     = ST_LOAD_R;
        end
      end
      default: begin
        state_d     = ST_LOAD_R;
        start_d     = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_LOAD_R;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_dist_q  <= '0;
      res_mx_q    <= '0;
      res_my_q    <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_dist_q  <= res_dist_d;
      res_mx_q    <= res_mx_d;
      res_my_q    <= res_my_d;
    end
  end

  assign r_we         = beat && (state_q == ST_LOAD_R);
  assign r_addr       = count[7:0];
  assign r_wdata      = px.in_data;
  assign s_we         = beat && (state_q == ST_LOAD_S);
  assign s_addr       = count;
  assign s_wdata      = px.in_data;
  assign start        = start_q;
  assign busy         = !((state_q == ST_LOAD_R) && (count == '0));
  assign px.res_valid = res_valid_q;
  assign px.res_dist  = res_dist_q;
  assign px.res_mx    = res_mx_q;
  assign px.res_my    = res_my_q;

endmodule

// File: tb/tb_me_block_loader.sv
// Self-checking bench: frame-level reference model plus directed scenarios.
module tb_me_block_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       r_we, s_we, start, busy, completed;
  logic [7:0] r_addr, r_wdata, s_wdata, bestDistance;
  logic [9:0] s_addr;
  logic [3:0] motionX, motionY;

  me_block_loader_if pif();

  me_block_loader dut (
    .clock        (clock),
    .reset        (reset),
    .px           (pif),
    .r_we         (r_we),
    .r_addr       (r_addr),
    .r_wdata      (r_wdata),
    .s_we         (s_we),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .start        (start),
    .completed    (completed),
    .bestDistance (bestDistance),
    .motionX      (motionX),
    .motionY      (motionY),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: a frame is 1280 accepted beats, then a search, then a result.
  int         acc = 0;
  logic       exp_start = 0, exp_rv = 0, pend = 0;
  logic [7:0] exp_d = 0;
  logic [3:0] exp_mx = 0, exp_my = 0;
  int         rp = 0, sp = 0;
  logic       tb_beat = 0, tb_rst = 1;

  always @(negedge clock) begin
    logic exp_rdy, beat, old_rv;
    exp_rdy = !reset && (acc < 1280);
    beat    = pif.in_valid && exp_rdy;
    check("in_ready", pif.in_ready, exp_rdy);
    check("r_we", r_we, beat && (acc < 256));
    check("s_we", s_we, beat && (acc >= 256));
    if (beat && acc < 256) begin
      check("r_addr", r_addr, acc);
      check("r_wdata", r_wdata, pif.in_data);
    end
    if (beat && acc >= 256) begin
      check("s_addr", s_addr, acc - 256);
      check("s_wdata", s_wdata, pif.in_data);
    end
    check("start", start, exp_start);
    check("res_valid", pif.res_valid, exp_rv);
    check("busy", busy, !(acc == 0 && !exp_start));
    check("res_dist", pif.res_dist, exp_d);
    check("res_mx", pif.res_mx, exp_mx);
    check("res_my", pif.res_my, exp_my);
    if (r_we) rp++;
    if (s_we) sp++;
    tb_beat = pif.in_valid && pif.in_ready;
    tb_rst  = reset;

    old_rv = exp_rv;
    if (reset) begin
      acc = 0; exp_start = 0; exp_rv = 0; pend = 0;
      exp_d = 0; exp_mx = 0; exp_my = 0; rp = 0; sp = 0;
    end else begin
      if (pend) begin
        exp_d = bestDistance; exp_mx = motionX; exp_my = motionY;
        exp_rv = 1; pend = 0;
      end else if (exp_start && !old_rv && completed) begin
        pend = 1;
      end
      if (old_rv && pif.res_ready) begin
        check("r_we_pulses", rp, 256);
        check("s_we_pulses", sp, 1024);
        rp = 0; sp = 0;
        exp_rv = 0; exp_start = 0; acc = 0;
      end
      if (beat) begin
        acc++;
        if (acc == 1280) exp_start = 1;
      end
    end
  end

  // Stream driver: R[i]=i, S[j]=j[7:0]; index advances only on accepted beats.
  int drv_mode = 0;
  int idx = 0;
  initial begin
    pif.in_valid = 0;
    pif.in_data  = 0;
    forever begin
      int v;
      @(posedge clock); #1;
      if (tb_rst) idx = 0;
      else if (tb_beat) idx = (idx == 1279) ? 0 : idx + 1;
      case (drv_mode)
        1:       pif.in_valid = 1'b1;
        2:       pif.in_valid = 1'($urandom_range(0, 1));
        default: pif.in_valid = 1'b0;
      endcase
      v = (idx < 256) ? idx : idx - 256;
      pif.in_data = 8'(v);
    end
  end

  // Engine model: counts while start=1, raises completed after eng_delay cycles.
  int   eng_delay = 4111;
  int   eng_cnt = 0;
  logic stray = 0;
  initial begin
    completed = 0;
    forever begin
      @(posedge clock); #1;
      if (start) eng_cnt++;
      else eng_cnt = 0;
      completed = (start && eng_cnt >= eng_delay) || stray;
    end
  end

  task automatic wait_rv(input int maxc);
    int n = 0;
    while (!pif.res_valid && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check("res_valid_wait", pif.res_valid, 1'b1);
  endtask

  task automatic handshake();
    @(posedge clock); #1 pif.res_ready = 1;
    @(posedge clock); #1 pif.res_ready = 0;
    @(negedge clock);
    check("start_after_hs", start, 1'b0);
    check("in_ready_after_hs", pif.in_ready, 1'b1);
  endtask

  initial begin
    reset = 1;
    pif.res_ready = 0;
    bestDistance = 8'h12; motionX = 4'd3; motionY = 4'hD;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check("rst_in_ready", pif.in_ready, 1'b1);
    check("rst_start", start, 1'b0);
    check("rst_res_valid", pif.res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_dist", pif.res_dist, 8'h00);

    // Frame 1: continuous stream, long search, result held off for 20 cycles.
    @(posedge clock); #1 drv_mode = 1;
    wait_rv(8000);
    repeat (20) begin
      @(negedge clock);
      check("hold_dist", pif.res_dist, 8'h12);
      check("hold_mx", pif.res_mx, 4'd3);
      check("hold_my", pif.res_my, 4'hD);
      check("hold_start", start, 1'b1);
      check("hold_valid", pif.res_valid, 1'b1);
    end
    handshake();

    // Frame 2: 50% gaps, stray completed during LOAD_R.
    drv_mode = 2; eng_delay = 30;
    bestDistance = 8'h45; motionX = 4'd7; motionY = 4'd2;
    @(posedge clock); #1 stray = 1;
    @(posedge clock); #1 stray = 0;
    @(negedge clock);
    check("stray_start", start, 1'b0);
    wait_rv(8000);
    @(negedge clock);
    check("f2_dist", pif.res_dist, 8'h45);
    check("f2_mx", pif.res_mx, 4'd7);
    check("f2_my", pif.res_my, 4'd2);
    handshake();

    // Frame 3: reset at search beat 600, then a clean reload.
    drv_mode = 1; eng_delay = 10;
    begin
      int n = 0;
      while (!(s_we && s_addr == 10'd600) && n < 4000) begin
        @(negedge clock);
        n++;
      end
      check("reach_s600", s_addr, 10'd600);
    end
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    check("abort_start", start, 1'b0);
    check("abort_in_ready", pif.in_ready, 1'b1);
    check("abort_r_we", r_we, 1'b1);
    check("abort_r_addr", r_addr, 8'h00);
    wait_rv(4000);
    handshake();
    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
